// File: rtl/video_timing_core_if.sv
// video_timing_core_if
//   Bundles the per-pixel colour request and the VGA connector pins.
//   master : the timing core. It reads red/green/blue and drives the VGA_* pins.
//   slave  : the pixel source / DAC side. It drives red/green/blue and reads the VGA_* pins.
interface video_timing_core_if;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;
   logic       VGA_CLK;
   logic       VGA_SYNC_N;
   logic       VGA_BLANK_N;
   logic       VGA_HS;
   logic       VGA_VS;

   modport master (
      input  red, green, blue,
      output VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
   );

   modport slave (
      output red, green, blue,
      input  VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
   );
endinterface

// File: rtl/video_timing_core.sv
// video_timing_core
//   Derives the slow game clock and the 640x480@60 VGA pixel clock, sync and
//   blank timing from the 50 MHz board clock. It passes pixel colour to the DAC
//   pins while the beam is in the visible region.
// Ports:
//   clk     in   board clock, all flops on its rising edge
//   reset   in   synchronous, active-high
//   div     in   game-clock half-period in clk cycles (0 and 1 both mean 1)
//   new_clk out  divided game clock
//   vga     master modport: red/green/blue in, VGA_* pins out
module video_timing_core #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [25:0]                div,
   output logic                       new_clk,
   video_timing_core_if.master        vga
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   // Line layout from h=0: sync, back porch, visible, front porch.
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
   localparam logic [HW-1:0] H_VIS_BEG  = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
   localparam logic [VW-1:0] V_VIS_BEG  = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_SYNC + V_BACK + V_VISIBLE);

   logic [25:0]   cnt_q, cnt_d;
   logic          new_clk_q, new_clk_d;
   logic          pix_q;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          blank_n_q, blank_n_d;
   logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;

   logic div_hit;
   logic pix_tick;
   logic visible;

   // cnt >= div-1 written as cnt+1 >= div so that div=0 cannot underflow.
   // A lowered div therefore ends the current half-period at once.
   assign div_hit  = ({1'b0, cnt_q} + 27'd1) >= {1'b0, div};
   assign pix_tick = ~pix_q;
   assign visible  = (h_q >= H_VIS_BEG) && (h_q < H_VIS_END) &&
                     (v_q >= V_VIS_BEG) && (v_q < V_VIS_END);

   always_comb begin
      cnt_d     = cnt_q + 26'd1;
      new_clk_d = new_clk_q;
      if (div_hit) begin
         cnt_d     = '0;
         new_clk_d = ~new_clk_q;
      end
   end

   always_comb begin
      h_d       = h_q;
      v_d       = v_q;
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
      r_d       = r_q;
      g_d       = g_q;
      b_d       = b_q;
      if (pix_tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
         end else begin
            h_d = h_q + HW'(1);
         end
         // Outputs come from the counter state before it advances.
         hs_d      = (h_q >= H_SYNC_END);
         vs_d      = (v_q >= V_SYNC_END);
         blank_n_d = visible;
         r_d       = visible ? vga.red   : 8'd0;
         g_d       = visible ? vga.green : 8'd0;
         b_d       = visible ? vga.blue  : 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         new_clk_q <= 1'b0;
         pix_q     <= 1'b0;
         h_q       <= '0;
         v_q       <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         cnt_q     <= cnt_d;
         new_clk_q <= new_clk_d;
         pix_q     <= ~pix_q;
         h_q       <= h_d;
         v_q       <= v_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         blank_n_q <= blank_n_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign new_clk         = new_clk_q;
   assign vga.VGA_CLK     = pix_q;
   assign vga.VGA_SYNC_N  = 1'b0;
   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
   assign vga.VGA_BLANK_N = blank_n_q;
   assign vga.VGA_R       = r_q;
   assign vga.VGA_G       = g_q;
   assign vga.VGA_B       = b_q;

endmodule

// File: tb/tb_video_timing_core.sv
// Bench for video_timing_core: one full-size instance and one instance with a
// tiny raster so that whole frames fit in a short run. Both share stimulus.
module tb_video_timing_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [25:0] div;
   logic [7:0]  r_in, g_in, b_in;
   logic        nclk_f, nclk_s;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   video_timing_core_if vif_f ();
   video_timing_core_if vif_s ();

   assign vif_f.red   = r_in;
   assign vif_f.green = g_in;
   assign vif_f.blue  = b_in;
   assign vif_s.red   = r_in;
   assign vif_s.green = g_in;
   assign vif_s.blue  = b_in;

   video_timing_core dut_f (
      .clk     (clk),
      .reset   (reset),
      .div     (div),
      .new_clk (nclk_f),
      .vga     (vif_f)
   );

   // Small raster: line 3+2+8+2 = 15 pixels, frame 2+2+4+1 = 9 lines.
   video_timing_core #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2)
   ) dut_s (
      .clk     (clk),
      .reset   (reset),
      .div     (div),
      .new_clk (nclk_s),
      .vga     (vif_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {HS, VS, BLANK_N, RGB} after pixel tick k since reset release,
   // from the raster position that tick k sees.
   function automatic logic [26:0] vid_exp(input int hs, input int hb, input int hv, input int hf,
                                           input int vs, input int vb, input int vv, input int vf,
                                           input longint k, input logic [23:0] rgb);
      longint htot, vtot, pos, h, v;
      logic   blank;
      htot  = hs + hb + hv + hf;
      vtot  = vs + vb + vv + vf;
      pos   = k % (htot * vtot);
      h     = pos % htot;
      v     = pos / htot;
      blank = (h >= hs + hb) && (h < hs + hb + hv) && (v >= vs + vb) && (v < vs + vb + vv);
      return {(h >= hs), (v >= vs), blank, blank ? rgb : 24'd0};
   endfunction

   localparam logic [26:0] RST_VID = {1'b1, 1'b1, 1'b0, 24'd0};

   // Model state
   bit          armed = 1'b0;
   longint      e;
   int          run;
   logic        m_nclk;
   logic [26:0] exp_f, exp_s;

   // Statistics since the last reset, sampled on pixel ticks
   int st_f_hs_low, st_f_blank, st_s_vs_low, st_s_blank, st_s_aa, st_s_rgb_dark;

   initial begin : compare_proc
      logic        rst_s;
      logic [25:0] div_s;
      logic [23:0] rgb_s;
      logic        pix_exp;
      int          lim;
      longint      k;
      forever begin
         @(posedge clk);
         rst_s = reset;
         div_s = div;
         rgb_s = {r_in, g_in, b_in};
         #1;
         if (rst_s) begin
            armed  = 1'b1;
            e      = -1;
            run    = 0;
            m_nclk = 1'b0;
            exp_f  = RST_VID;
            exp_s  = RST_VID;
            st_f_hs_low = 0; st_f_blank = 0; st_s_vs_low = 0;
            st_s_blank  = 0; st_s_aa    = 0; st_s_rgb_dark = 0;
         end else if (armed) begin
            e++;
            // Half-period ends once div cycles (at least one) have elapsed.
            lim = (div_s <= 26'd1) ? 1 : int'(div_s);
            if (run + 1 >= lim) begin
               m_nclk = ~m_nclk;
               run    = 0;
            end else begin
               run++;
            end
            if (e % 2 == 0) begin
               k     = e / 2;
               exp_f = vid_exp(96, 48, 640, 16, 2, 33, 480, 10, k, rgb_s);
               exp_s = vid_exp(3, 2, 8, 2, 2, 2, 4, 1, k, rgb_s);
               if (k < 800) begin
                  st_f_hs_low += int'(!vif_f.VGA_HS);
                  st_f_blank  += int'(vif_f.VGA_BLANK_N);
               end
               if (k < 135) begin
                  st_s_vs_low += int'(!vif_s.VGA_VS);
                  st_s_blank  += int'(vif_s.VGA_BLANK_N);
                  st_s_aa     += int'(vif_s.VGA_BLANK_N && vif_s.VGA_R == 8'hAA &&
                                      vif_s.VGA_G == 8'hAA && vif_s.VGA_B == 8'hAA);
                  st_s_rgb_dark += int'(!vif_s.VGA_BLANK_N && {vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B} == 24'd0);
               end
            end
         end
         if (armed) begin
            pix_exp = !rst_s && (e % 2 == 0);
            check("new_clk_f", nclk_f, m_nclk);
            check("new_clk_s", nclk_s, m_nclk);
            check("vga_clk_f", vif_f.VGA_CLK, pix_exp);
            check("vga_clk_s", vif_s.VGA_CLK, pix_exp);
            check("sync_n_f",  vif_f.VGA_SYNC_N, 1'b0);
            check("sync_n_s",  vif_s.VGA_SYNC_N, 1'b0);
            check("video_f", {vif_f.VGA_HS, vif_f.VGA_VS, vif_f.VGA_BLANK_N,
                              vif_f.VGA_R, vif_f.VGA_G, vif_f.VGA_B}, exp_f);
            check("video_s", {vif_s.VGA_HS, vif_s.VGA_VS, vif_s.VGA_BLANK_N,
                              vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B}, exp_s);
         end
      end
   end

   task automatic check_reset_pins(input string tag);
      check({tag, "_hs"},    vif_f.VGA_HS & vif_s.VGA_HS, 1'b1);
      check({tag, "_vs"},    vif_f.VGA_VS & vif_s.VGA_VS, 1'b1);
      check({tag, "_blank"}, vif_f.VGA_BLANK_N | vif_s.VGA_BLANK_N, 1'b0);
      check({tag, "_clk"},   vif_f.VGA_CLK | vif_s.VGA_CLK, 1'b0);
      check({tag, "_rgb"},   {vif_f.VGA_R, vif_f.VGA_G, vif_f.VGA_B}, 24'd0);
      check({tag, "_nclk"},  nclk_f | nclk_s, 1'b0);
   endtask

   initial begin : stim_proc
      logic [15:0] pat4;
      logic [6:0]  pat3;
      pat4 = 16'b0111_1000_0111_1000;   // new_clk after edges 0..15 with div=4
      pat3 = 7'b1000111;                // new_clk after edges 7..13 (bit0 = edge 7)
      reset = 1'b1;
      div   = 26'd4;
      r_in  = 8'hAA; g_in = 8'hAA; b_in = 8'hAA;
      repeat (3) @(negedge clk);
      check_reset_pins("reset");

      // Phase 1: constant colour, div=4
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("div4_pattern", nclk_f, pat4[i]);
         if (i == 0) begin
            check("first_tick_hs", vif_f.VGA_HS, 1'b0);
            check("first_tick_vs", vif_f.VGA_VS, 1'b0);
            check("first_tick_clk", vif_f.VGA_CLK, 1'b1);
         end
      end
      repeat (1700 - 16) @(negedge clk);
      check("line0_hs_low_ticks",    st_f_hs_low, 96);
      check("line0_blank_ticks",     st_f_blank, 0);
      check("frame_s_vs_low_ticks",  st_s_vs_low, 30);
      check("frame_s_blank_ticks",   st_s_blank, 32);
      check("frame_s_aa_ticks",      st_s_aa, 32);
      check("frame_s_dark_ticks",    st_s_rgb_dark, 135 - 32);

      // Phase 2: div lowered 10 -> 3 while cnt=7
      reset = 1'b1;
      div   = 26'd10;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("div10_low", nclk_f, 1'b0);
      end
      div = 26'd3;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("div_lowered", nclk_f, pat3[i]);
      end

      // Phase 3: random colour and divider, with one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         r_in = 8'($urandom);
         g_in = 8'($urandom);
         b_in = 8'($urandom);
         if ($urandom_range(0, 39) == 0) div = 26'($urandom_range(0, 12));
         if (i == 1777) begin
            reset = 1'b1;
            @(negedge clk);
            check_reset_pins("midrun_reset");
            reset = 1'b0;
         end
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
